icon_row_prefetch: RTL and testbench

- Per-line scheduler for the shared icon image ROM (9-bit address = {4-bit image id, 5-bit row}, one 32-pixel row per word).
- During horizontal blanking it decides which icon slots intersect the next scan line and issues one ROM read per active slot via a request/grant handshake. Each returned row is stored in a shadow buffer.
- At the start of the line, the shadow buffer is copied into output registers, which the pixel mux reads during active video.

---
 rtl/icon_row_prefetch.sv | 181 ++++++++++++++++++
 tb/tb_icon_row_prefetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/icon_row_prefetch.sv
// Icon row prefetcher: during hblank, fetches one ROM row per icon slot that hits
// the next scan line into a shadow buffer, and publishes it on line_swap.
module icon_row_prefetch #(
   parameter int N_SLOTS = 6,
   parameter int ROM_LAT = 2,
   parameter int DATA_W  = 32
) (
   input  logic                        reloj,
   input  logic                        resetM,
   input  logic                        hblank_start,
   input  logic                        line_swap,
   input  logic [9:0]                  line_next,
   input  logic                        F_H,
   input  logic                        AM_PM,
   output logic                        rom_req,
   output logic [8:0]                  rom_addr,
   input  logic                        rom_gnt,
   input  logic [DATA_W-1:0]           rom_data,
   output logic [N_SLOTS*DATA_W-1:0]   slot_rows,
   output logic [N_SLOTS-1:0]          slot_valid,
   output logic                        busy,
   output logic                        overrun
);

   localparam int IDX_W = $clog2(N_SLOTS);
   localparam int CNT_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);
   // Slot k image id at [k*4 +: 4], cell row at [k*5 +: 5].
   localparam logic [23:0] SLOT_IDS   = {4'd4, 4'd1, 4'd6, 4'd5, 4'd2, 4'd3};
   localparam logic [29:0] SLOT_CELLS = {5'd12, 5'd7, 5'd6, 5'd5, 5'd3, 5'd3};

   typedef enum logic [1:0] {IDLE, SCAN, REQ, WAIT} state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [9:0]         line_reg;
   logic               f_h_reg, am_pm_reg;
   logic [N_SLOTS-1:0] shadow_valid_reg, slot_valid_reg;
   logic [N_SLOTS-1:0] slot_active, keep_mask;
   logic               overrun_reg;
   logic               capture, clear_valid, abort;
   logic [3:0]         id_sel;

   genvar gi;
   generate
      for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
         logic              slot_en;
         logic [DATA_W-1:0] shadow_reg;
         logic [DATA_W-1:0] rows_reg;

         if (gi == 2) begin : g_am
            assign slot_en = f_h_reg & ~am_pm_reg;
         end else if (gi == 3) begin : g_pm
            assign slot_en = f_h_reg & am_pm_reg;
         end else begin : g_always
            assign slot_en = 1'b1;
         end

         assign slot_active[gi] = slot_en && (line_reg[9:5] == SLOT_CELLS[gi*5 +: 5]);
         // Slots already finished for the current line survive an aborted scan.
         assign keep_mask[gi]   = (IDX_W'(gi) < idx_reg);

         always_ff @(posedge reloj) begin
            if (!resetM) begin
               shadow_reg <= '0;
               rows_reg   <= '0;
            end else begin
               if (capture && (idx_reg == IDX_W'(gi)))
                  shadow_reg <= rom_data;
               if (line_swap)
                  rows_reg <= shadow_reg;
            end
         end

         assign slot_rows[gi*DATA_W +: DATA_W] = rows_reg;
      end
   endgenerate

   always_comb begin
      id_sel = '0;
      for (int k = 0; k < N_SLOTS; k++)
         if (idx_reg == IDX_W'(k))
            id_sel = SLOT_IDS[k*4 +: 4];
   end

   assign busy     = (state_reg != IDLE);
   assign rom_req  = (state_reg == REQ);
   assign rom_addr = rom_req ? {id_sel, line_reg[4:0]} : 9'd0;
   assign abort    = line_swap & busy;

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      cnt_next    = cnt_reg;
      capture     = 1'b0;
      clear_valid = 1'b0;
      case (state_reg)
         IDLE: ;
         SCAN: begin
            if (slot_active[idx_reg]) begin
               state_next = REQ;
            end else begin
               clear_valid = 1'b1;
               if (idx_reg == LAST_IDX)
                  state_next = IDLE;
               else
                  idx_next = idx_reg + 1'b1;
            end
         end
         REQ: begin
            if (rom_gnt) begin
               cnt_next   = CNT_W'(ROM_LAT);
               state_next = WAIT;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
               capture = 1'b1;
               if (idx_reg == LAST_IDX) begin
                  state_next = IDLE;
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = SCAN;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      // A new line or a swap mid-scan discards whatever the scan was doing, including data in flight.
      if (hblank_start) begin
         state_next  = SCAN;
         idx_next    = '0;
         capture     = 1'b0;
         clear_valid = 1'b0;
      end else if (abort) begin
         state_next  = IDLE;
         idx_next    = '0;
         capture     = 1'b0;
         clear_valid = 1'b0;
      end
   end

   always_ff @(posedge reloj) begin
      if (!resetM) begin
         state_reg        <= IDLE;
         idx_reg          <= '0;
         cnt_reg          <= '0;
         line_reg         <= '0;
         f_h_reg          <= 1'b0;
         am_pm_reg        <= 1'b0;
         shadow_valid_reg <= '0;
         slot_valid_reg   <= '0;
         overrun_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         if (hblank_start) begin
            line_reg  <= line_next;
            f_h_reg   <= F_H;
            am_pm_reg <= AM_PM;
         end
         if ((hblank_start || line_swap) && busy)
            overrun_reg <= 1'b1;
         if (line_swap)
            slot_valid_reg <= busy ? (shadow_valid_reg & keep_mask) : shadow_valid_reg;
         if (abort)
            shadow_valid_reg <= shadow_valid_reg & keep_mask;
         else if (capture)
            shadow_valid_reg[idx_reg] <= 1'b1;
         else if (clear_valid)
            shadow_valid_reg[idx_reg] <= 1'b0;
      end
   end

   assign slot_valid = slot_valid_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_icon_row_prefetch.sv
// Bench for icon_row_prefetch: directed scenarios plus random traffic, all checked
// against an edge-timeline reference model of the slot table and fetch timing.
module tb_icon_row_prefetch;
   localparam int N   = 6;
   localparam int LAT = 2;
   localparam int DW  = 32;

   logic              reloj = 1'b0;
   logic              resetM, hblank_start, line_swap, F_H, AM_PM, rom_gnt;
   logic              rom_req, busy, overrun;
   logic [9:0]        line_next;
   logic [8:0]        rom_addr;
   logic [DW-1:0]     rom_data;
   logic [N*DW-1:0]   slot_rows;
   logic [N-1:0]      slot_valid;

   icon_row_prefetch #(.N_SLOTS(N), .ROM_LAT(LAT), .DATA_W(DW)) dut (
      .reloj(reloj), .resetM(resetM), .hblank_start(hblank_start), .line_swap(line_swap),
      .line_next(line_next), .F_H(F_H), .AM_PM(AM_PM), .rom_req(rom_req), .rom_addr(rom_addr),
      .rom_gnt(rom_gnt), .rom_data(rom_data), .slot_rows(slot_rows), .slot_valid(slot_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 reloj = ~reloj;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Slot table: image id and cell row per slot.
   int ids[N]   = '{3, 2, 5, 6, 1, 4};
   int cells[N] = '{3, 3, 5, 6, 7, 12};

   function automatic logic [31:0] rom_word(input int a);
      return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0F0F) ^ 32'(a);
   endfunction

   // Reference model: timeline of edges numbered k.
   int          k = 1;
   bit          m_on;
   int          m_j, m_t, m_g, m_line;
   bit          m_fh, m_ap, m_ovr;
   logic [DW-1:0] m_shadow[N];
   logic [DW-1:0] m_pub[N];
   bit [N-1:0]  m_sv, m_pv;

   // ROM model: delivery ring keyed by edge number.
   bit          ring_v[16];
   int          ring_a[16];
   int          gnt_hold = 0;
   bit          gnt_rand = 0;

   function automatic bit slot_act(input int s, input int ln, input bit fh, input bit ap);
      bit en;
      en = (s == 2) ? (fh && !ap) : (s == 3) ? (fh && ap) : 1'b1;
      return en && ((ln / 32) == cells[s]);
   endfunction

   task automatic model_edge(input bit hb, input bit sw, input bit rn, input int ln,
                             input bit fh, input bit ap, input bit granted);
      bit done;
      if (!rn) begin
         m_on = 0; m_ovr = 0; m_sv = '0; m_pv = '0;
         for (int s = 0; s < N; s++) begin m_shadow[s] = '0; m_pub[s] = '0; end
         return;
      end
      if (sw) begin
         for (int s = 0; s < N; s++) m_pub[s] = m_shadow[s];
         if (m_on) for (int s = 0; s < N; s++) if (s >= m_j) m_sv[s] = 1'b0;
         m_pv = m_sv;
      end
      if ((hb || sw) && m_on) m_ovr = 1;
      if (hb) begin
         m_on = 1; m_j = 0; m_t = k; m_g = -1; m_line = ln; m_fh = fh; m_ap = ap;
      end else if (sw && m_on) begin
         m_on = 0;
      end else if (m_on) begin
         done = 0;
         if (granted) m_g = k;
         if (!slot_act(m_j, m_line, m_fh, m_ap)) begin
            if (k == m_t + 1) begin m_sv[m_j] = 1'b0; done = 1; end
         end else if (m_g >= 0 && k == m_g + LAT) begin
            m_shadow[m_j] = rom_word(ids[m_j] * 32 + m_line % 32);
            m_sv[m_j] = 1'b1;
            done = 1;
         end
         if (done) begin
            if (m_j == N - 1) m_on = 0;
            else begin m_j++; m_t = k; m_g = -1; end
         end
      end
   endtask

   // One clock cycle: check outputs, drive inputs, advance model, cross edge k.
   task automatic cyc(input bit hb, input bit sw, input bit rn, input int ln, input bit fh, input bit ap);
      bit exp_req;
      int exp_addr;
      @(negedge reloj);
      exp_req  = m_on && slot_act(m_j, m_line, m_fh, m_ap) && (m_g < 0) && (k >= m_t + 2);
      exp_addr = exp_req ? (ids[m_j] * 32 + m_line % 32) : 0;
      check_val("busy", busy, m_on);
      check_val("rom_req", rom_req, exp_req);
      check_val("rom_addr", rom_addr, exp_addr);
      check_val("overrun", overrun, m_ovr);
      check_val("slot_valid", slot_valid, m_pv);
      for (int s = 0; s < N; s++)
         check_val($sformatf("slot_row%0d", s), slot_rows[s*DW +: DW], m_pub[s]);
      resetM = rn; hblank_start = hb; line_swap = sw;
      line_next = 10'(ln); F_H = fh; AM_PM = ap;
      if (gnt_hold > 0) begin rom_gnt = 1'b0; gnt_hold--; end
      else rom_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rom_req && rom_gnt) begin
         ring_v[(k + LAT) % 16] = 1;
         ring_a[(k + LAT) % 16] = int'(rom_addr);
         $display("read %03h granted at edge %0d", rom_addr, k);
      end
      rom_data = ring_v[k % 16] ? rom_word(ring_a[k % 16]) : $urandom;
      ring_v[k % 16] = 0;
      if (sw) $display("line_swap at edge %0d (busy=%0d)", k, m_on);
      if (!rn) $display("reset at edge %0d", k);
      model_edge(hb, sw, rn, ln, fh, ap, exp_req && rom_gnt);
      @(posedge reloj);
      k++;
   endtask

   task automatic run_line(input int ln, input bit fh, input bit ap, input int gap);
      cyc(1, 0, 1, ln, fh, ap);
      repeat (gap) cyc(0, 0, 1, ln, fh, ap);
      cyc(0, 1, 1, ln, fh, ap);
      #1;
   endtask

   int lines[7] = '{103, 160, 196, 255, 400, 96, 380};

   initial begin
      resetM = 0; hblank_start = 0; line_swap = 0; line_next = 0;
      F_H = 0; AM_PM = 0; rom_gnt = 1; rom_data = '0;
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);

      // Two slots on cell row 3, grant always high.
      run_line(103, 0, 0, 12);
      check_val("t1_valid", slot_valid, 6'b000011);
      check_val("t1_row0", slot_rows[0 +: DW], rom_word(9'h067));
      check_val("t1_row1", slot_rows[DW +: DW], rom_word(9'h047));

      // AM slot, then same line with 24-hour format.
      run_line(160, 1, 0, 10);
      check_val("t2_am_valid", slot_valid, 6'b000100);
      check_val("t2_am_row", slot_rows[2*DW +: DW], rom_word(9'h0A0));
      cyc(1, 0, 1, 160, 0, 0);
      repeat (6) cyc(0, 0, 1, 160, 0, 0);
      #1 check_val("t2_busy_done", busy, 1'b0);
      cyc(0, 1, 1, 160, 0, 0);
      #1 check_val("t2_24h_valid", slot_valid, 6'b000000);

      // PM, calendar and avatar slots.
      run_line(196, 1, 1, 10);
      check_val("t3_pm_valid", slot_valid, 6'b001000);
      check_val("t3_pm_row", slot_rows[3*DW +: DW], rom_word(9'h0C4));
      run_line(255, 0, 0, 10);
      check_val("t3_cal_valid", slot_valid, 6'b010000);
      check_val("t3_cal_row", slot_rows[4*DW +: DW], rom_word(9'h03F));
      run_line(400, 0, 0, 10);
      check_val("t3_av_valid", slot_valid, 6'b100000);
      check_val("t3_av_row", slot_rows[5*DW +: DW], rom_word(9'h090));

      // Grant withheld for five request cycles.
      gnt_hold = 7;
      run_line(103, 0, 0, 20);
      check_val("t4_valid", slot_valid, 6'b000011);
      check_val("t4_row0", slot_rows[0 +: DW], rom_word(9'h067));

      // Swap three cycles into the scan.
      cyc(1, 0, 1, 103, 0, 0);
      cyc(0, 0, 1, 103, 0, 0);
      cyc(0, 0, 1, 103, 0, 0);
      cyc(0, 1, 1, 103, 0, 0);
      #1;
      check_val("t5_overrun", overrun, 1'b1);
      check_val("t5_valid_lo", slot_valid[1:0], 2'b00);
      check_val("t5_busy", busy, 1'b0);
      run_line(103, 0, 0, 12);
      check_val("t5_sticky", overrun, 1'b1);
      check_val("t5_clean_valid", slot_valid, 6'b000011);

      // Reset during WAIT.
      cyc(1, 0, 1, 103, 0, 0);
      cyc(0, 0, 1, 103, 0, 0);
      cyc(0, 0, 1, 103, 0, 0);
      cyc(0, 0, 0, 103, 0, 0);
      #1;
      check_val("t6_busy", busy, 1'b0);
      check_val("t6_req", rom_req, 1'b0);
      check_val("t6_addr", rom_addr, 9'd0);
      check_val("t6_overrun", overrun, 1'b0);
      check_val("t6_valid", slot_valid, 6'b000000);
      check_val("t6_rows", slot_rows == '0, 1'b1);
      run_line(103, 0, 0, 12);
      check_val("t6_after_valid", slot_valid, 6'b000011);
      check_val("t6_after_row1", slot_rows[DW +: DW], rom_word(9'h047));

      // Random traffic with random grants, overlapping pulses and occasional resets.
      gnt_rand = 1;
      for (int c = 0; c < 2000; c++) begin
         int ln;
         bit hb, sw, rn;
         ln = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : lines[$urandom_range(0, 6)];
         hb = ($urandom_range(0, 24) == 0);
         sw = ($urandom_range(0, 24) == 0);
         rn = ($urandom_range(0, 399) != 0);
         cyc(hb, sw, rn, ln, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      gnt_rand = 0;
      repeat (30) cyc(0, 0, 1, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
